// File: rtl/timer_alarm.sv
// Compare/alarm stage behind the 64-bit free-running time counter: one-shot or
// periodic deadline with a level irq and a saturating missed-alarm counter.
module timer_alarm #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MISS_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W-1:0]   timer_value,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  cmp_lo_wr,
  input  logic                  cmp_hi_wr,
  input  logic                  period_wr,
  input  logic                  mode,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic                  irq_ack,
  output logic                  irq,
  output logic                  armed,
  output logic [2*DATA_W-1:0]   cmp_value,
  output logic [MISS_W-1:0]     miss_cnt
);

  localparam int unsigned CntW = 2 * DATA_W;
  localparam logic [MISS_W-1:0] MissMax = '1;

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e              state_q, state_d;
  logic                irq_q, irq_d;
  logic [CntW-1:0]     cmp_q, cmp_d;
  logic [CntW-1:0]     period_q, period_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                hit;

  // >= rather than == so skipped or stalled counter values still trigger.
  assign hit = (state_q == StArmed) && (timer_value >= cmp_q);

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    cmp_d    = cmp_q;
    period_d = period_q;
    shadow_d = shadow_q;
    miss_d   = miss_q;

    if (cmp_lo_wr) shadow_d = wdata;
    if (period_wr) period_d = {{DATA_W{1'b0}}, wdata};
    if (irq_ack)   irq_d    = 1'b0;

    if (disarm) begin
      state_d = StIdle;
    end else if (arm && (state_q == StIdle)) begin
      state_d = StArmed;
    end else if (hit) begin
      irq_d = 1'b1;
      // An ack in the hit cycle consumes the old pending alarm, so no miss.
      if (irq_q && !irq_ack && (miss_q != MissMax)) miss_d = miss_q + 1'b1;
      if (!mode || (period_q == '0)) begin
        state_d = StIdle;
      end else begin
        cmp_d = cmp_q + period_q;
      end
    end

    // A software write overrides any reload computed this cycle.
    if (cmp_hi_wr) cmp_d = {wdata, (cmp_lo_wr ? wdata : shadow_q)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      irq_q    <= 1'b0;
      cmp_q    <= '0;
      period_q <= '0;
      shadow_q <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
      shadow_q <= shadow_d;
      miss_q   <= miss_d;
    end
  end

  assign irq       = irq_q;
  assign armed     = (state_q == StArmed);
  assign cmp_value = cmp_q;
  assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: expected alarm times are queued as
// stimulus is set up and popped when irq rises.
module tb_timer_alarm;

  logic        clk;
  logic        rst;
  logic [63:0] timer_value;
  logic [31:0] wdata;
  logic        cmp_lo_wr, cmp_hi_wr, period_wr, mode, arm, disarm, irq_ack;
  logic        irq, armed;
  logic [63:0] cmp_value;
  logic [7:0]  miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  timer_alarm #(.DATA_W(32), .MISS_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .timer_value (timer_value),
    .wdata       (wdata),
    .cmp_lo_wr   (cmp_lo_wr),
    .cmp_hi_wr   (cmp_hi_wr),
    .period_wr   (period_wr),
    .mode        (mode),
    .arm         (arm),
    .disarm      (disarm),
    .irq_ack     (irq_ack),
    .irq         (irq),
    .armed       (armed),
    .cmp_value   (cmp_value),
    .miss_cnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // One clock edge; outputs are sampled 1 time unit later, strobes are dropped.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 0; cmp_lo_wr = 0; cmp_hi_wr = 0; period_wr = 0;
    arm = 0; disarm = 0; irq_ack = 0;
  endtask

  task automatic write_cmp(input logic [63:0] v);
    wdata = v[31:0];  cmp_lo_wr = 1; step();
    wdata = v[63:32]; cmp_hi_wr = 1; step();
  endtask

  task automatic do_reset();
    rst = 1; step();
    exp_q.delete();
  endtask

  // Count the timer up from start; every irq rising edge must match the queue head.
  task automatic run_timer(input logic [63:0] start, input int n, input bit ack);
    logic prev;
    logic [63:0] exp;
    for (int i = 0; i < n; i++) begin
      timer_value = start + 64'(i);
      irq_ack = ack && irq;
      prev = irq;
      step();
      if (irq && !prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL alarm_unexpected: irq rose at timer %0h, required no alarm",
                   start + 64'(i));
        end else begin
          exp = exp_q.pop_front();
          if (start + 64'(i) !== exp) begin
            errors++;
            $display("FAIL alarm_time: irq rose at timer %0h, required %0h",
                     start + 64'(i), exp);
          end
        end
      end
    end
    while (exp_q.size() != 0) begin
      checks++;
      errors++;
      exp = exp_q.pop_front();
      $display("FAIL alarm_missing: no irq seen, required alarm at timer %0h", exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (irq !== 1'b0)     begin errors++; $display("FAIL reset_irq: got %b, required 0", irq); end
    if (armed !== 1'b0)   begin errors++; $display("FAIL reset_armed: got %b, required 0", armed); end
    if (cmp_value !== '0) begin errors++; $display("FAIL reset_cmp: got %0h, required 0", cmp_value); end
    if (miss_cnt !== '0)  begin errors++; $display("FAIL reset_miss: got %0d, required 0", miss_cnt); end
  endtask

  task automatic test_oneshot();
    do_reset();
    mode = 0;
    write_cmp(64'd100);
    checks++;
    if (cmp_value !== 64'd100) begin
      errors++; $display("FAIL oneshot_cmp: got %0h, required 64", cmp_value);
    end
    timer_value = 0; arm = 1; step();
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL oneshot_armed: got %b, required 1", armed); end
    exp_q.push_back(64'd100);
    run_timer(64'd0, 110, 1'b0);
    checks += 2;
    if (irq !== 1'b1)   begin errors++; $display("FAIL oneshot_irq_hold: got %b, required 1", irq); end
    if (armed !== 1'b0) begin errors++; $display("FAIL oneshot_disarmed: got %b, required 0", armed); end
    irq_ack = 1; step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_ack: got %b, required 0", irq); end
  endtask

  task automatic test_periodic();
    do_reset();
    write_cmp(64'd50);
    wdata = 20; period_wr = 1; step();
    mode = 1; timer_value = 0; arm = 1; step();
    for (int k = 0; k < 4; k++) exp_q.push_back(64'd50 + 64'(20 * k));
    run_timer(64'd0, 115, 1'b1);
    checks += 3;
    if (cmp_value !== 64'd130) begin errors++; $display("FAIL periodic_cmp: got %0d, required 130", cmp_value); end
    if (miss_cnt !== 8'd0)     begin errors++; $display("FAIL periodic_miss: got %0d, required 0", miss_cnt); end
    if (armed !== 1'b1)        begin errors++; $display("FAIL periodic_armed: got %b, required 1", armed); end
  endtask

  task automatic test_missed();
    do_reset();
    write_cmp(64'd0);
    wdata = 1; period_wr = 1; step();
    mode = 1; timer_value = 64'd1000; arm = 1; step();
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (miss_cnt !== 8'd4) begin errors++; $display("FAIL miss_count: got %0d, required 4", miss_cnt); end
    irq_ack = 1; step();
    checks += 2;
    if (irq !== 1'b1)      begin errors++; $display("FAIL miss_ack_hit_irq: got %b, required 1", irq); end
    if (miss_cnt !== 8'd4) begin errors++; $display("FAIL miss_ack_hit_cnt: got %0d, required 4", miss_cnt); end
    for (int k = 0; k < 300; k++) step();
    checks += 3;
    if (miss_cnt !== 8'd255)   begin errors++; $display("FAIL miss_saturate: got %0d, required 255", miss_cnt); end
    if (irq !== 1'b1)          begin errors++; $display("FAIL miss_irq: got %b, required 1", irq); end
    if (cmp_value !== 64'd306) begin errors++; $display("FAIL miss_cmp: got %0d, required 306", cmp_value); end
  endtask

  task automatic test_atomic();
    do_reset();
    mode = 0;
    timer_value = 64'h1_0000_0000;
    write_cmp(64'h2_0000_0000);
    arm = 1; step();
    wdata = 32'h10; cmp_lo_wr = 1; step();
    checks += 2;
    if (irq !== 1'b0) begin errors++; $display("FAIL atomic_lo_irq: got %b, required 0", irq); end
    if (cmp_value !== 64'h2_0000_0000) begin
      errors++; $display("FAIL atomic_lo_cmp: got %0h, required 200000000", cmp_value);
    end
    wdata = 32'h1; cmp_hi_wr = 1; step();
    checks += 2;
    if (irq !== 1'b0) begin errors++; $display("FAIL atomic_hi_irq: got %b, required 0", irq); end
    if (cmp_value !== 64'h1_0000_0010) begin
      errors++; $display("FAIL atomic_hi_cmp: got %0h, required 100000010", cmp_value);
    end
    exp_q.push_back(64'h1_0000_0010);
    run_timer(64'h1_0000_0000, 24, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    write_cmp(64'hFFFF_FFFF_FFFF_FFFB);
    wdata = 10; period_wr = 1; step();
    mode = 1; timer_value = 64'hFFFF_FFFF_FFFF_FFFD; arm = 1; step();
    step();
    checks += 2;
    if (irq !== 1'b1)        begin errors++; $display("FAIL wrap_hit: got %b, required 1", irq); end
    if (cmp_value !== 64'd5) begin errors++; $display("FAIL wrap_cmp: got %0h, required 5", cmp_value); end
    step();
    checks += 2;
    if (cmp_value !== 64'd15) begin errors++; $display("FAIL wrap_catchup_cmp: got %0h, required f", cmp_value); end
    if (miss_cnt !== 8'd1)    begin errors++; $display("FAIL wrap_catchup_miss: got %0d, required 1", miss_cnt); end
    timer_value = 0; step();
    checks++;
    if (cmp_value !== 64'd15) begin errors++; $display("FAIL wrap_counter_reset: got %0h, required f", cmp_value); end
  endtask

  task automatic test_priority();
    do_reset();
    mode = 0;
    write_cmp(64'd10);
    timer_value = 0; arm = 1; step();
    timer_value = 20; disarm = 1; step();
    checks += 3;
    if (irq !== 1'b0)         begin errors++; $display("FAIL disarm_irq: got %b, required 0", irq); end
    if (armed !== 1'b0)       begin errors++; $display("FAIL disarm_state: got %b, required 0", armed); end
    if (cmp_value !== 64'd10) begin errors++; $display("FAIL disarm_cmp: got %0d, required 10", cmp_value); end
    mode = 1; wdata = 5; period_wr = 1; step();
    timer_value = 0; arm = 1; step();
    timer_value = 20; wdata = 1; cmp_hi_wr = 1; step();
    checks += 2;
    if (irq !== 1'b1) begin errors++; $display("FAIL write_vs_hit_irq: got %b, required 1", irq); end
    if (cmp_value !== 64'h1_0000_000A) begin
      errors++; $display("FAIL write_vs_hit_cmp: got %0h, required 10000000a", cmp_value);
    end
    write_cmp(64'd0);
    for (int k = 0; k < 3; k++) step();
    checks += 3;
    if (miss_cnt !== 8'd3) begin errors++; $display("FAIL pre_rst_miss: got %0d, required 3", miss_cnt); end
    if (armed !== 1'b1)    begin errors++; $display("FAIL pre_rst_armed: got %b, required 1", armed); end
    if (irq !== 1'b1)      begin errors++; $display("FAIL pre_rst_irq: got %b, required 1", irq); end
    rst = 1; step();
    checks += 4;
    if (irq !== 1'b0)     begin errors++; $display("FAIL rst_irq: got %b, required 0", irq); end
    if (armed !== 1'b0)   begin errors++; $display("FAIL rst_armed: got %b, required 0", armed); end
    if (cmp_value !== '0) begin errors++; $display("FAIL rst_cmp: got %0h, required 0", cmp_value); end
    if (miss_cnt !== '0)  begin errors++; $display("FAIL rst_miss: got %0d, required 0", miss_cnt); end
    wdata = 32'h7; cmp_hi_wr = 1; step();
    checks++;
    if (cmp_value !== 64'h7_0000_0000) begin
      errors++; $display("FAIL rst_shadow: got %0h, required 700000000", cmp_value);
    end
  endtask

  initial begin
    rst = 1; timer_value = 0; wdata = 0; cmp_lo_wr = 0; cmp_hi_wr = 0;
    period_wr = 0; mode = 0; arm = 0; disarm = 0; irq_ack = 0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_missed();
    test_atomic();
    test_wrap();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_alarm.md
Name: timer_alarm

Overview:
- Compare/alarm stage that sits directly downstream of the 64-bit free-running time counter.
- Consumes the live counter value and raises a level interrupt when a programmed 64-bit deadline is reached.
- Supports one-shot and periodic (auto-reload) modes, plus a saturating missed-alarm counter.
- Software-facing control arrives as decoded single-cycle strobes from the peripheral register file.

Parameters:
- DATA_W, 32, CPU data word width; the compare value and counter width are 2*DATA_W.
- MISS_W, 8, width of the saturating missed-alarm counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset; combined hard/soft reset, sampled on clk rising edge.
- timer_value  in  2*DATA_W  live counter value from the time counter.
- wdata  in  DATA_W  write data shared by all write strobes.
- cmp_lo_wr  in  1  strobe: load wdata into the low shadow register.
- cmp_hi_wr  in  1  strobe: commit {wdata, shadow_lo} to the compare register atomically.
- period_wr  in  1  strobe: load wdata into the period register (zero-extended to 2*DATA_W).
- mode  in  1  0 = one-shot, 1 = periodic; sampled at each hit.
- arm  in  1  strobe: ARMED state entry.
- disarm  in  1  strobe: return to IDLE.
- irq_ack  in  1  strobe: clear irq.
- irq  out  1  pending alarm, level.
- armed  out  1  high while in ARMED.
- cmp_value  out  2*DATA_W  current compare register.
- miss_cnt  out  MISS_W  saturating count of hits that occurred while irq was already pending.

Behaviour:
- Reset values: irq=0, armed=0, cmp_value=0, shadow_lo=0, period=0, miss_cnt=0, state=IDLE.
- States:
  - IDLE: no compare activity; arm goes to ARMED.
  - ARMED: hit = (timer_value >= cmp_value), unsigned 2*DATA_W compare.
    - Using >= rather than == tolerates skipped counter values and a stalled counter.
- Hit timing:
  - The hit is combinational; irq and state update on the next clk edge, so irq rises 1 cycle after timer_value first satisfies the compare.
- On a hit in ARMED:
  - irq <= 1.
  - If irq was already 1 before the hit, miss_cnt += 1; it saturates at 2^MISS_W-1 and never wraps.
  - mode=0 or period=0: go to IDLE (armed <= 0).
  - mode=1 and period!=0: stay ARMED; cmp_value <= cmp_value + period, modulo 2^(2*DATA_W).
    - Wrap-around is allowed.
    - A reload that wraps below timer_value hits on the next cycle; this is the intended catch-up behaviour, one hit per cycle.
- Compare writes:
  - cmp_lo_wr writes shadow_lo only.
  - cmp_hi_wr writes cmp_value = {wdata, shadow_lo} in one cycle, so a half-updated deadline is never compared.
  - cmp_lo_wr and cmp_hi_wr in the same cycle: cmp_value = {wdata, wdata}, and shadow_lo is also updated.
- Simultaneous events, priority highest first:
  1. rst.
  2. disarm: wins over arm and hit; no irq is set and no reload happens that cycle.
  3. arm.
  4. cmp_hi_wr vs. hit: the hit is evaluated against the old cmp_value and the reload is discarded; the written value wins.
- irq_ack:
  - irq_ack with a hit in the same cycle leaves irq=1 (set wins) and does not count a miss.
  - irq_ack does not change state or miss_cnt.
- arm:
  - arm while already ARMED is a no-op.
  - arm when cmp_value <= timer_value gives an immediate hit on the next cycle.
- Other rules:
  - period_wr takes effect for the next reload only.
  - timer_value decreasing (counter reset) needs no special handling; hits resume once the compare is satisfied again.
  - rst mid-operation returns every register to its reset value on the next edge, including any pending irq.

Test Plan:
- One-shot: cmp written lo=100, hi=0; arm; timer counting from 0 -> irq rises the cycle after timer_value=100; armed=0; irq stays 1 until irq_ack.
- Periodic: cmp=50, period=20, mode=1; ack every hit -> irq at timer 50, 70, 90, 110; cmp_value=130 after the 4th hit; miss_cnt=0.
- Missed alarms: periodic with period=1 and no ack for 300 cycles -> miss_cnt saturates at 255; irq_ack in the same cycle as a hit keeps irq=1.
- Atomic write: timer=0x1_0000_0000; write lo=0x10, then hi=0x1, armed -> no hit between the two writes; hit after timer reaches 0x1_0000_0010.
- Wrap and late arm: cmp=2^64-5, period=10, timer=2^64-3 at arm -> immediate hit; cmp_value=5 after reload, then a hit on the next cycle.
- Priority and reset: disarm together with a hit -> irq=0, state IDLE. rst asserted while irq=1, ARMED and miss_cnt=3 -> all outputs 0 on the next edge.
